// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: CPU memory-window bus between the keyboard window decoder and ps2_host_tx.
// The width of mem_addr comes from KB_ADDR_WIDTH, which defaults to 8 when it is not defined.
`ifndef KB_ADDR_WIDTH
`define KB_ADDR_WIDTH 8
`endif

interface ps2_host_tx_if;
  logic                       mem_write;
  logic                       mem_read;
  logic [`KB_ADDR_WIDTH-1:0]  mem_addr;
  logic [31:0]                mem_wdata;
  logic [31:0]                mem_rdata;

  modport master (
    output mem_write, mem_read, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_write, mem_read, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (LED set, reset, typematic, ...).
// The CPU writes a byte to TX_DATA (0x03). The block then runs the sequence inhibit,
// request-to-send, the 11-clock frame and the ACK sample on the open-drain ps2_clk/ps2_data
// pads. STATUS (0x04) = {28'b0, drop, error, ack, busy}.
// Build macro PS2_TX_AUTO_RETRY_EN: a NACK or a timeout restarts the frame from inhibit,
// with up to 2 retries. error is set only after the third failure.
//
// state     | meaning
// S_IDLE    | both lines released, waiting for a TX_DATA write
// S_INHIBIT | ps2_clk held low for INHIBIT_CYCLES
// S_START   | ps2_data pulled low (start bit) for one cycle with clock still held
// S_FRAME   | device clocks the frame; data bits/parity/stop, ACK sampled on edge 11
// S_WAIT_IDLE | waiting for the device to release both lines
`ifndef KB_ADDR_WIDTH
`define KB_ADDR_WIDTH 8
`endif

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  output logic         tx_active,
  ps2_host_tx_if.slave bus
);

  localparam int AW         = `KB_ADDR_WIDTH;
  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_TX     = AW'(3);
  localparam logic [AW-1:0] ADDR_STATUS = AW'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_FRAME,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          parity_q, parity_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_q, ack_d;
  logic          error_q, error_d;
  logic          drop_q, drop_d;
  logic          busy_q, busy_d;
  logic          active_q, active_d;
  logic [31:0]   rdata_q, rdata_d;
`ifdef PS2_TX_AUTO_RETRY_EN
  logic [1:0]    retry_q, retry_d;
`endif

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  logic        clk_fall;
  logic        timer_zero;
  logic        wr_tx;
  logic        fail;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^bus.mem_wdata[31:8];

  // Two-flop synchronisers for the asynchronous pad inputs plus a delayed copy for edge detect.
  // They reset to 1 (released bus) so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_fall   = clk_prev_q & ~clk_sync_q;
  assign timer_zero = (timer_q == '0);
  assign wr_tx      = bus.mem_write && (bus.mem_addr == ADDR_TX);
  assign status     = {28'b0, drop_q, error_q, ack_q, busy_q};

  // Next-state, line and status computation for the transmit sequencer and register read.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    error_d   = error_q;
    drop_d    = drop_q;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    fail      = 1'b0;
`ifdef PS2_TX_AUTO_RETRY_EN
    retry_d   = retry_q;
`endif

    // Reads see the status from before any write made in the same cycle.
    if (bus.mem_read) begin
      rdata_d = (bus.mem_addr == ADDR_STATUS) ? status : 32'h0;
    end

    if (wr_tx && busy_q) begin
      drop_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (wr_tx) begin
          byte_d   = bus.mem_wdata[7:0];
          parity_d = ~^bus.mem_wdata[7:0];
          ack_d    = 1'b0;
          error_d  = 1'b0;
          drop_d   = 1'b0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          timer_d  = INH_LOAD;
          state_d  = S_INHIBIT;
`ifdef PS2_TX_AUTO_RETRY_EN
          retry_d  = 2'd0;
`endif
        end
      end

      S_INHIBIT: begin
        if (timer_zero) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_START: begin
        clk_oe_d  = 1'b0;
        bit_idx_d = 4'd0;
        timer_d   = TO_LOAD;
        state_d   = S_FRAME;
      end

      S_FRAME: begin
        if (clk_fall) begin
          timer_d   = TO_LOAD;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < 4'd8) begin
            data_oe_d = ~byte_q[bit_idx_q[2:0]];
          end else if (bit_idx_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else if (bit_idx_q == 4'd9) begin
            data_oe_d = 1'b0;
          end else if (!data_sync_q) begin
            ack_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (timer_zero) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (clk_fall) begin
          timer_d = TO_LOAD;
        end else if (timer_zero) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // NACK or timeout: release the bus; either retry from inhibit or finish with error.
    // ack is cleared here so ack and error can never both be set.
    if (fail) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      ack_d     = 1'b0;
      error_d   = 1'b1;
      busy_d    = 1'b0;
      state_d   = S_IDLE;
`ifdef PS2_TX_AUTO_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d  = retry_q + 2'd1;
        error_d  = error_q;
        busy_d   = 1'b1;
        clk_oe_d = 1'b1;
        timer_d  = INH_LOAD;
        state_d  = S_INHIBIT;
      end
`endif
    end

    active_d = (state_d != S_IDLE);
  end

  // Sequencer state, pad enables, status bits and read data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 4'd0;
      byte_q    <= 8'h0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
      active_q  <= 1'b0;
      rdata_q   <= 32'h0;
`ifdef PS2_TX_AUTO_RETRY_EN
      retry_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      parity_q  <= parity_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      error_q   <= error_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
      active_q  <= active_d;
      rdata_q   <= rdata_d;
`ifdef PS2_TX_AUTO_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_data_oe   = data_oe_q;
  assign tx_active     = active_q;
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and randomized bench for ps2_host_tx with a PS/2 device model.
`timescale 1ns/1ps
`ifndef KB_ADDR_WIDTH
`define KB_ADDR_WIDTH 8
`endif

module tb_ps2_host_tx;
  localparam int INH  = 200;
  localparam int TO   = 3000;
  localparam int HALF = 20;
  localparam int AW   = `KB_ADDR_WIDTH;
`ifdef PS2_TX_AUTO_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe, tx_active;
  wire  clk_line  = dev_clk & ~ps2_clk_oe;
  wire  data_line = dev_data & ~ps2_data_oe;

  int checks = 0;
  int failures = 0;

  ps2_host_tx_if bus();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_active   (tx_active),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Bus monitors, sampling the pre-edge values at each rising clock edge.
  int   cyc = 0;
  int   rise_cyc = 0;
  int   last_inh = 0;
  int   stab_viol = 0;
  int   act_low = 0;
  int   dev_edges = 0;
  int   fall_cyc = 0;
  bit   mon_en = 1'b0;
  logic prev_coe = 1'b0;
  logic prev_doe = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ps2_clk_oe === 1'b1 && prev_coe !== 1'b1) rise_cyc = cyc;
    if (ps2_clk_oe !== 1'b1 && prev_coe === 1'b1) last_inh = cyc - rise_cyc;
    if (mon_en && clk_line === 1'b1 && ps2_data_oe !== prev_doe) stab_viol = stab_viol + 1;
    if (mon_en && tx_active !== 1'b1) act_low = act_low + 1;
    prev_coe = ps2_clk_oe;
    prev_doe = ps2_data_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame as the device should see it: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic bus_cycle(input bit wr, input bit rd, input logic [7:0] addr,
                           input logic [31:0] wd, output logic [31:0] rv);
    @(negedge clk);
    bus.mem_write = wr;
    bus.mem_read  = rd;
    bus.mem_addr  = AW'(addr);
    bus.mem_wdata = wd;
    @(negedge clk);
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    rv = bus.mem_rdata;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_cycle(1'b1, 1'b0, addr, wd, dummy);
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] rv);
    bus_cycle(1'b0, 1'b1, addr, 32'h0, rv);
  endtask

  // Device model: waits for request-to-send, then generates nclk clocks, sampling data on
  // each rising edge 1..10 and driving ACK (or NACK) on clock 11.
  task automatic device_frame(input int nclk, input bit nack, output logic [10:0] bits,
                              output bit ok);
    int t;
    ok = 1'b1;
    bits = 'x;
    dev_edges = 0;
    t = 0;
    while (ps2_clk_oe !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    while (ps2_clk_oe === 1'b1 && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin
      ok = 1'b0;
      return;
    end
    bits[0] = data_line;
    stab_viol = 0;
    act_low = 0;
    mon_en = 1'b1;
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11) begin
        mon_en = 1'b0;
        dev_data = nack;
      end
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      dev_edges = i;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = data_line;
      repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
    mon_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (tx_active !== 1'b0 && t < 20000) begin @(negedge clk); t++; end
    chk({tag, "_idle"}, tx_active, 1'b0);
  endtask

  task automatic run_tx(input logic [7:0] b, input bit nack, input string tag);
    logic [10:0] bits;
    logic [31:0] rd;
    bit ok;
    int n;
    n = nack ? ATTEMPTS : 1;
    bus_write(8'h03, {24'h0, b});
    for (int a = 0; a < n; a++) begin
      device_frame(11, nack, bits, ok);
      chk({tag, "_req"}, ok, 1'b1);
      chk({tag, "_bits"}, bits, frame_of(b));
      chk({tag, "_inhibit"}, (last_inh >= INH - 1 && last_inh <= INH + 1), 1'b1);
      chk({tag, "_stable"}, stab_viol, 0);
      chk({tag, "_active"}, act_low, 0);
    end
    wait_idle(tag);
    bus_read(8'h04, rd);
    chk({tag, "_status"}, rd, nack ? 32'h4 : 32'h2);
  endtask

  initial begin
    logic [31:0] rd;
    logic [10:0] bits;
    logic [10:0] ref_f;
    logic [7:0]  b;
    bit ok;
    int t;
    int el;

    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_active", tx_active, 1'b0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(8'h04, rd);
    chk("rst_status", rd, 32'h0);

    // LED-set command acknowledged, then register read behaviour
    run_tx(8'hED, 1'b0, "led_ed");
    repeat (4) @(negedge clk);
    chk("rdata_hold", bus.mem_rdata, 32'h2);
    bus_read(8'h07, rd);
    chk("other_addr", rd, 32'h0);
    bus_read(8'h03, rd);
    chk("txdata_read", rd, 32'h0);

    // Reset command, all ones
    run_tx(8'hFF, 1'b0, "reset_ff");

    // NACK from device
    run_tx(8'h55, 1'b1, "nack");

    // Randomized bytes and responses
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      run_tx(b, ($urandom_range(0, 3) == 0), $sformatf("rand%0d_%02h", k, b));
    end

    // Device stops clocking after bit 3
    b = 8'hA5;
    ref_f = frame_of(b);
    bus_write(8'h03, {24'h0, b});
    for (int a = 0; a < ATTEMPTS; a++) begin
      device_frame(4, 1'b0, bits, ok);
      chk("to_req", ok, 1'b1);
      chk("to_bits", bits[3:0], ref_f[3:0]);
      t = 0;
      while (!(ps2_clk_oe === 1'b1 || tx_active === 1'b0) && t < 2 * TO) begin
        @(negedge clk);
        t++;
      end
      el = cyc - fall_cyc;
      chk("to_len", (el >= TO && el <= TO + 10), 1'b1);
    end
    wait_idle("to");
    chk("to_clk_rel", ps2_clk_oe, 1'b0);
    chk("to_data_rel", ps2_data_oe, 1'b0);
    bus_read(8'h04, rd);
    chk("to_status", rd, 32'h4);

    // Second write in the middle of a frame
    b = 8'h3C;
    bus_write(8'h03, {24'h0, b});
    fork
      device_frame(11, 1'b0, bits, ok);
      begin
        t = 0;
        while (dev_edges < 4 && t < 5000) begin @(negedge clk); t++; end
        bus_write(8'h03, 32'h99);
        bus_read(8'h04, rd);
        chk("drop_busy_status", rd, 32'h9);
      end
    join
    chk("drop_req", ok, 1'b1);
    chk("drop_bits", bits, frame_of(b));
    wait_idle("drop");
    bus_read(8'h04, rd);
    chk("drop_done_status", rd, 32'hA);
    run_tx(8'($urandom), 1'b0, "drop_clear");

    // Reset in the middle of bit 5
    b = 8'h6B;
    bus_write(8'h03, {24'h0, b});
    fork
      device_frame(11, 1'b0, bits, ok);
      begin
        t = 0;
        while (!(dev_edges >= 5 && dev_clk === 1'b0) && t < 5000) begin @(negedge clk); t++; end
        repeat (8) @(negedge clk);
        chk("mid_data_oe_set", ps2_data_oe, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("mid_rst_data_oe", ps2_data_oe, 1'b0);
      end
    join
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_active", tx_active, 1'b0);
    bus_read(8'h04, rd);
    chk("mid_rst_status", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
